// File: rtl/heading_move_tracker.sv
// heading_move_tracker
// Executes single-cell moves on a bounded GRID_W x GRID_H grid, driven by the
// 4-bit heading code from the upstream heading state machine. Each request
// accepted in IDLE is closed by exactly one move_ack pulse. A legal move
// spends MOVE_CYCLES cycles in MOVE before the position updates. Blocked
// moves (grid edge) and illegal codes (> 3) acknowledge on the next cycle
// and change nothing.
//
// Ports
//   CLK        : clock, rising edge
//   nRESET     : synchronous reset, active high (1 = reset)
//   heading    : 0 north(+y), 1 west(-x), 2 east(+x), 3 south(-y), 4..15 illegal
//   move_req   : move request level, sampled in IDLE only
//   move_ack   : one-cycle pulse closing every accepted request
//   busy       : high while a legal move is in progress
//   pos_x      : current X cell
//   pos_y      : current Y cell
//   blocked    : pulse alongside move_ack when the move would leave the grid
//   illegal    : pulse alongside move_ack when heading > 3
//   move_count : completed legal moves, saturating at all-ones
module heading_move_tracker #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 16,
  parameter int XW          = 4,
  parameter int YW          = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [3:0]       heading,
  input  logic             move_req,
  output logic             move_ack,
  output logic             busy,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic             blocked,
  output logic             illegal,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              TW         = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [XW-1:0]   X_MAX      = XW'(GRID_W - 1);
  localparam logic [YW-1:0]   Y_MAX      = YW'(GRID_H - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_dir;
  logic [TW-1:0]    r_timer;
  logic [XW-1:0]    r_pos_x;
  logic [YW-1:0]    r_pos_y;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_ack;
  logic             r_blocked;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_illegal;
  logic             w_at_edge;
  logic             w_timer_done;
  logic             w_blocked_next;
  logic             w_illegal_next;

  assign w_accept     = (r_state == S_IDLE) && move_req;
  assign w_is_illegal = (heading > 4'd3);
  assign w_timer_done = (r_timer == '0);

  // Edge test uses the live heading: it only matters at the acceptance edge,
  // which is also where the heading is latched.
  always_comb begin
    case (heading[1:0])
      2'd0:    w_at_edge = (r_pos_y == Y_MAX);
      2'd1:    w_at_edge = (r_pos_x == '0);
      2'd2:    w_at_edge = (r_pos_x == X_MAX);
      default: w_at_edge = (r_pos_y == '0);
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_next   = r_state;
    w_blocked_next = 1'b0;
    w_illegal_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (move_req) begin
          if (w_is_illegal) begin
            w_state_next   = S_DONE;
            w_illegal_next = 1'b1;
          end else if (w_at_edge) begin
            w_state_next   = S_DONE;
            w_blocked_next = 1'b1;
          end else begin
            w_state_next   = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (w_timer_done) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Flag outputs are registered from the next-state decode so they line up
  // exactly with the cycle spent in each state.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (nRESET) begin
      r_state   <= S_IDLE;
      r_dir     <= 2'd0;
      r_timer   <= '0;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_blocked <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_busy    <= (w_state_next == S_MOVE);
      r_ack     <= (w_state_next == S_DONE);
      r_blocked <= w_blocked_next;
      r_illegal <= w_illegal_next;

      if (w_accept) begin
        r_dir   <= heading[1:0];
        r_timer <= TIMER_LOAD;
      end else if ((r_state == S_MOVE) && !w_timer_done) begin
        r_timer <= r_timer - TW'(1);
      end

      // Bounds were checked at acceptance, so the step here cannot wrap.
      if ((r_state == S_MOVE) && w_timer_done) begin
        case (r_dir)
          2'd0:    r_pos_y <= r_pos_y + YW'(1);
          2'd1:    r_pos_x <= r_pos_x - XW'(1);
          2'd2:    r_pos_x <= r_pos_x + XW'(1);
          default: r_pos_y <= r_pos_y - YW'(1);
        endcase
        if (r_count != '1) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign move_ack   = r_ack;
  assign busy       = r_busy;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign blocked    = r_blocked;
  assign illegal    = r_illegal;
  assign move_count = r_count;

endmodule

// File: tb/tb_heading_move_tracker.sv
// Testbench for heading_move_tracker.
// Stimulus issues requests and pushes the expected acknowledge (time, flags,
// resulting position and count) into a queue from a grid model; a negedge
// monitor pops and compares whenever move_ack is seen and checks busy.
module tb_heading_move_tracker;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int XW     = 4;
  localparam int YW     = 4;
  localparam int MC     = 4;
  localparam int CNT_W  = 16;

  logic             CLK = 1'b0;
  logic             nRESET = 1'b1;
  logic [3:0]       heading = 4'd0;
  logic             move_req = 1'b0;
  logic             move_ack;
  logic             busy;
  logic [XW-1:0]    pos_x;
  logic [YW-1:0]    pos_y;
  logic             blocked;
  logic             illegal;
  logic [CNT_W-1:0] move_count;

  heading_move_tracker #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
    .MOVE_CYCLES(MC), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .heading(heading), .move_req(move_req),
    .move_ack(move_ack), .busy(busy), .pos_x(pos_x), .pos_y(pos_y),
    .blocked(blocked), .illegal(illegal), .move_count(move_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int acc;      // cycle index of the acceptance edge
    int ack_cyc;  // cycle index at which move_ack must be seen
    bit legal;
    bit blk;
    bit ill;
    int x;
    int y;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_reset = 1'b1;
  int   mx = 0, my = 0, mcnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per move_ack, checks busy every cycle.
  exp_t mon_e;
  logic mon_busy;
  always @(negedge CLK) begin
    if (!in_reset) begin
      mon_busy = 1'b0;
      if (q.size() > 0)
        mon_busy = q[0].legal && (cyc >= q[0].acc) && (cyc < q[0].acc + MC);
      check("busy", {31'd0, busy}, {31'd0, mon_busy});
      if (move_ack) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with no request outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("ack_time", cyc, mon_e.ack_cyc);
          check("blocked", {31'd0, blocked}, {31'd0, mon_e.blk});
          check("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
          check("pos_x", {28'd0, pos_x}, mon_e.x);
          check("pos_y", {28'd0, pos_y}, mon_e.y);
          check("move_count", {16'd0, move_count}, mon_e.cnt);
        end
      end else begin
        check("flags_without_ack", {30'd0, blocked, illegal}, 32'd0);
        if (q.size() > 0 && cyc > q[0].ack_cyc) begin
          checks++;
          errors++;
          $display("FAIL ack_timeout: no ack by cycle %0d expected at %0d", cyc, q[0].ack_cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  // Model of one request: compute the move on the grid with plain arithmetic.
  task automatic do_move(input logic [3:0] h, input bit scramble);
    exp_t e;
    int nx, ny, period;
    @(negedge CLK);
    heading  = h;
    move_req = 1'b1;
    e.acc = cyc + 1;
    nx = mx;
    ny = my;
    case (h)
      4'd0: ny = my + 1;
      4'd1: nx = mx - 1;
      4'd2: nx = mx + 1;
      4'd3: ny = my - 1;
      default: ;
    endcase
    e.ill   = (h > 4'd3);
    e.blk   = !e.ill && (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H);
    e.legal = !e.ill && !e.blk;
    if (e.legal) begin
      mx = nx;
      my = ny;
      if (mcnt < (1 << CNT_W) - 1) mcnt++;
    end
    e.x = mx;
    e.y = my;
    e.cnt = mcnt;
    e.ack_cyc = e.legal ? e.acc + MC : e.acc;
    period = e.legal ? MC + 2 : 2;
    q.push_back(e);
    @(posedge CLK);
    // Until the next possible acceptance, heading and req must be ignored.
    for (int i = 0; i < period - 1; i++) begin
      @(negedge CLK);
      if (scramble) begin
        heading  = 4'($urandom_range(0, 15));
        move_req = 1'($urandom_range(0, 1));
      end
      @(posedge CLK);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      move_req = 1'b0;
      @(posedge CLK);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    in_reset = 1'b1;
    move_req = 1'b0;
    nRESET   = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs",
          {move_ack, busy, blocked, illegal, pos_x, pos_y, move_count}, 32'd0);
    nRESET = 1'b0;
    q.delete();
    mx = 0; my = 0; mcnt = 0;
    @(posedge CLK);
    in_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] h;

    // Reset, then 10 idle cycles with nothing changing.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_quiet",
            {move_ack, busy, blocked, illegal, pos_x, pos_y, move_count}, 32'd0);
    end

    // Single north move from (0,0).
    do_move(4'd0, 1'b0);
    idle(2);
    check("north_pos_y", {28'd0, pos_y}, 32'd1);

    // West from (0,0) is blocked.
    apply_reset();
    do_move(4'd1, 1'b0);
    idle(2);

    // East held for 20 back-to-back requests: climbs to 15 then blocks.
    apply_reset();
    for (int i = 0; i < 20; i++) do_move(4'd2, 1'b0);
    idle(2);
    check("east_final_x", {28'd0, pos_x}, 32'd15);
    check("east_final_count", {16'd0, move_count}, 32'd15);

    // Illegal code, then a legal move whose heading is scrambled mid-move.
    apply_reset();
    do_move(4'h7, 1'b0);
    do_move(4'd0, 1'b1);
    idle(2);

    // Reach (3,3), start a north move, reset while timer == 1.
    apply_reset();
    for (int i = 0; i < 3; i++) do_move(4'd2, 1'b0);
    for (int i = 0; i < 3; i++) do_move(4'd0, 1'b0);
    idle(1);
    check("pre_abort_x", {28'd0, pos_x}, 32'd3);
    check("pre_abort_y", {28'd0, pos_y}, 32'd3);
    in_reset = 1'b1;
    @(negedge CLK);
    heading  = 4'd0;
    move_req = 1'b1;
    @(posedge CLK);                 // acceptance, timer loads MC-1
    @(negedge CLK);
    move_req = 1'b0;
    heading  = 4'd3;
    @(posedge CLK);                 // timer 2
    @(negedge CLK);
    @(posedge CLK);                 // timer 1
    @(negedge CLK);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    nRESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_state",
          {move_ack, busy, blocked, illegal, pos_x, pos_y, move_count}, 32'd0);
    nRESET = 1'b0;
    mx = 0; my = 0; mcnt = 0;
    q.delete();
    @(posedge CLK);
    @(negedge CLK);
    check("abort_no_late_ack", {31'd0, move_ack}, 32'd0);
    @(posedge CLK);
    in_reset = 1'b0;

    // Randomized phase: mostly legal headings, random gaps and scrambling.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      h = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      do_move(h, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("queue_drained", q.size(), 32'd0);
    @(negedge CLK);
    check("final_pos_x", {28'd0, pos_x}, mx);
    check("final_pos_y", {28'd0, pos_y}, my);
    check("final_count", {16'd0, move_count}, mcnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
